// File: rtl/sal_bank_timer_pkg.sv
// -----------------------------------------------------------------------------
// sal_bank_timer_pkg
// Shared definitions for the per-bank timing tracker. The scheduler and the
// other banks import the same state encoding and default widths.
//   bank_state_t : IDLE / ACTIVE / REFRESH bank state
//   TW_DEF       : default timing counter width
//   OCW_DEF      : default open-row idle counter width
//   CNT_*        : slot indices of the TW-wide constraint counters
// -----------------------------------------------------------------------------
package sal_bank_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_REFRESH = 2'd2
    } bank_state_t;

    localparam int TW_DEF  = 8;
    localparam int OCW_DEF = 8;

    // Constraint counter slots (all TW bits wide)
    localparam int CNT_RC  = 0;
    localparam int CNT_RCD = 1;
    localparam int CNT_RAS = 2;
    localparam int CNT_RP  = 3;   // also carries tRFC after a REF
    localparam int CNT_RTP = 4;
    localparam int CNT_WTP = 5;
    localparam int N_CNT   = 6;

endpackage

// File: rtl/sal_dn_cnt.sv
// -----------------------------------------------------------------------------
// sal_dn_cnt
// Loadable down-counter that saturates at zero.
//   clk      : clock
//   rst_n    : synchronous active-low reset (count -> 0)
//   load     : load load_val at this edge
//   load_val : value to load (constraint minus one)
//   met      : count is zero; decoded from the register, no extra latency
// -----------------------------------------------------------------------------
module sal_dn_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         met
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign met = (cnt_reg == '0);

endmodule

// File: rtl/sal_bank_timer.sv
// -----------------------------------------------------------------------------
// sal_bank_timer
// Per-bank state machine and DRAM timing tracker. Reports which command class
// is legal each cycle, flags illegal commands and requests a precharge once
// an open row has been idle for row_open_cnt cycles.
//   t_*_m1        : timing constraints minus one, sampled when a command issues
//   row_open_cnt  : idle cycles before close_req_o
//   act/rd/wr/pre/ref_i : command strobes issued this cycle
//   row_i         : row address captured with act_i
//   *_ok_o        : command class legal this cycle
//   close_req_o   : open-row timeout reached
//   is_open_o     : bank ACTIVE
//   cur_row_o     : open row
//   err_o         : sticky illegal-command flag
// -----------------------------------------------------------------------------
module sal_bank_timer
    import sal_bank_timer_pkg::*;
#(
    parameter int TW    = TW_DEF,
    parameter int ROW_W = 16,
    parameter int OCW   = OCW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TW-1:0]    t_rc_m1,
    input  logic [TW-1:0]    t_rcd_m1,
    input  logic [TW-1:0]    t_rp_m1,
    input  logic [TW-1:0]    t_ras_m1,
    input  logic [TW-1:0]    t_rfc_m1,
    input  logic [TW-1:0]    t_rtp_m1,
    input  logic [TW-1:0]    t_wtp_m1,
    input  logic [OCW-1:0]   row_open_cnt,
    input  logic             act_i,
    input  logic             rd_i,
    input  logic             wr_i,
    input  logic             pre_i,
    input  logic             ref_i,
    input  logic [ROW_W-1:0] row_i,
    output logic             act_ok_o,
    output logic             rdwr_ok_o,
    output logic             pre_ok_o,
    output logic             ref_ok_o,
    output logic             close_req_o,
    output logic             is_open_o,
    output logic [ROW_W-1:0] cur_row_o,
    output logic             err_o
);

    bank_state_t      state_reg, state_next;
    logic [ROW_W-1:0] cur_row_reg;
    logic             err_reg;

    logic [N_CNT-1:0] cnt_load;
    logic [N_CNT-1:0] cnt_met;
    logic [TW-1:0]    cnt_val [N_CNT];
    logic             idle_met;

    logic             eff_idle, is_active;
    logic             act_ok, rdwr_ok, pre_ok, ref_ok;
    logic [2:0]       n_strobe;
    logic             bad_cmd;
    logic             act_v, rd_v, wr_v, pre_v, ref_v;

    // ------------------------------------------------------------------
    // Constraint counters
    // ------------------------------------------------------------------
    always_comb begin
        cnt_val[CNT_RC]  = t_rc_m1;
        cnt_val[CNT_RCD] = t_rcd_m1;
        cnt_val[CNT_RAS] = t_ras_m1;
        cnt_val[CNT_RP]  = ref_v ? t_rfc_m1 : t_rp_m1;
        cnt_val[CNT_RTP] = t_rtp_m1;
        cnt_val[CNT_WTP] = t_wtp_m1;

        cnt_load          = '0;
        cnt_load[CNT_RC]  = act_v;
        cnt_load[CNT_RCD] = act_v;
        cnt_load[CNT_RAS] = act_v;
        cnt_load[CNT_RP]  = pre_v | ref_v;
        cnt_load[CNT_RTP] = rd_v;
        cnt_load[CNT_WTP] = wr_v;
    end

    generate
        for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
            sal_dn_cnt #(.W(TW)) u_cnt (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (cnt_load[gi]),
                .load_val (cnt_val[gi]),
                .met      (cnt_met[gi])
            );
        end
    endgenerate

    sal_dn_cnt #(.W(OCW)) u_idle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (act_v | rd_v | wr_v),
        .load_val (row_open_cnt),
        .met      (idle_met)
    );

    // ------------------------------------------------------------------
    // Legality. The REFRESH->IDLE register update lands one edge after tRFC
    // expires, so a REFRESH bank whose rp counter has reached zero is
    // already treated as idle; that keeps ACT/REF legal exactly at N+tRFC.
    // ------------------------------------------------------------------
    assign is_active = (state_reg == ST_ACTIVE);
    assign eff_idle  = (state_reg == ST_IDLE) ||
                       ((state_reg == ST_REFRESH) && cnt_met[CNT_RP]);

    assign act_ok  = eff_idle & cnt_met[CNT_RC] & cnt_met[CNT_RP];
    assign ref_ok  = eff_idle & cnt_met[CNT_RP] & cnt_met[CNT_RC];
    assign rdwr_ok = is_active & cnt_met[CNT_RCD];
    assign pre_ok  = is_active & cnt_met[CNT_RAS] & cnt_met[CNT_RTP] & cnt_met[CNT_WTP];

    assign n_strobe = {2'b00, act_i} + {2'b00, rd_i} + {2'b00, wr_i} +
                      {2'b00, pre_i} + {2'b00, ref_i};

    assign bad_cmd = (n_strobe > 3'd1)              |
                     (act_i & ~act_ok)              |
                     ((rd_i | wr_i) & ~rdwr_ok)     |
                     (pre_i & ~pre_ok)              |
                     (ref_i & ~ref_ok);

    // Illegal commands are dropped entirely
    assign act_v = act_i & ~bad_cmd;
    assign rd_v  = rd_i  & ~bad_cmd;
    assign wr_v  = wr_i  & ~bad_cmd;
    assign pre_v = pre_i & ~bad_cmd;
    assign ref_v = ref_i & ~bad_cmd;

    // ------------------------------------------------------------------
    // Bank FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (act_v)      state_next = ST_ACTIVE;
                else if (ref_v) state_next = ST_REFRESH;
            end
            ST_REFRESH: begin
                if (act_v)                 state_next = ST_ACTIVE;
                else if (ref_v)            state_next = ST_REFRESH;
                else if (cnt_met[CNT_RP])  state_next = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (pre_v) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cur_row_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (act_v)   cur_row_reg <= row_i;
            if (bad_cmd) err_reg     <= 1'b1;
        end
    end

    assign act_ok_o    = act_ok;
    assign rdwr_ok_o   = rdwr_ok;
    assign pre_ok_o    = pre_ok;
    assign ref_ok_o    = ref_ok;
    assign close_req_o = is_active & idle_met;
    assign is_open_o   = is_active;
    assign cur_row_o   = cur_row_reg;
    assign err_o       = err_reg;

endmodule

// File: tb/tb_sal_bank_timer.sv
// -----------------------------------------------------------------------------
// tb_sal_bank_timer
// Directed scenarios; each expected output value is queued against the cycle
// it must appear in and compared at the falling edge of that cycle.
// -----------------------------------------------------------------------------
module tb_sal_bank_timer;

    localparam int TW    = 8;
    localparam int ROW_W = 16;
    localparam int OCW   = 8;

    localparam int S_ACT_OK  = 0;
    localparam int S_RDWR_OK = 1;
    localparam int S_PRE_OK  = 2;
    localparam int S_REF_OK  = 3;
    localparam int S_CLOSE   = 4;
    localparam int S_OPEN    = 5;
    localparam int S_ROW     = 6;
    localparam int S_ERR     = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [TW-1:0]    t_rc_m1, t_rcd_m1, t_rp_m1, t_ras_m1, t_rfc_m1, t_rtp_m1, t_wtp_m1;
    logic [OCW-1:0]   row_open_cnt;
    logic             act_i, rd_i, wr_i, pre_i, ref_i;
    logic [ROW_W-1:0] row_i;
    logic             act_ok_o, rdwr_ok_o, pre_ok_o, ref_ok_o;
    logic             close_req_o, is_open_o, err_o;
    logic [ROW_W-1:0] cur_row_o;

    always #5 clk = ~clk;

    sal_bank_timer #(.TW(TW), .ROW_W(ROW_W), .OCW(OCW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .t_rc_m1      (t_rc_m1),
        .t_rcd_m1     (t_rcd_m1),
        .t_rp_m1      (t_rp_m1),
        .t_ras_m1     (t_ras_m1),
        .t_rfc_m1     (t_rfc_m1),
        .t_rtp_m1     (t_rtp_m1),
        .t_wtp_m1     (t_wtp_m1),
        .row_open_cnt (row_open_cnt),
        .act_i        (act_i),
        .rd_i         (rd_i),
        .wr_i         (wr_i),
        .pre_i        (pre_i),
        .ref_i        (ref_i),
        .row_i        (row_i),
        .act_ok_o     (act_ok_o),
        .rdwr_ok_o    (rdwr_ok_o),
        .pre_ok_o     (pre_ok_o),
        .ref_ok_o     (ref_ok_o),
        .close_req_o  (close_req_o),
        .is_open_o    (is_open_o),
        .cur_row_o    (cur_row_o),
        .err_o        (err_o)
    );

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   cur;
    bit   in_reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    function automatic logic [31:0] get_sig(input int sel);
        case (sel)
            S_ACT_OK:  return {31'd0, act_ok_o};
            S_RDWR_OK: return {31'd0, rdwr_ok_o};
            S_PRE_OK:  return {31'd0, pre_ok_o};
            S_REF_OK:  return {31'd0, ref_ok_o};
            S_CLOSE:   return {31'd0, close_req_o};
            S_OPEN:    return {31'd0, is_open_o};
            S_ROW:     return {16'd0, cur_row_o};
            default:   return {31'd0, err_o};
        endcase
    endfunction

    // Insert keeping the queue sorted by cycle
    task automatic expect_at(input int c, input int sel, input logic [31:0] v, input string tag);
        exp_t e;
        int   pos;
        e.cyc = c; e.sel = sel; e.val = v;
        e.tag = $sformatf("%s@%0d", tag, c);
        pos = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc > c) begin
                pos = i;
                break;
            end
        end
        exp_q.insert(pos, e);
    endtask

    // Compare this cycle's outputs at negedge, then advance one cycle
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (!in_reset) begin
            while (exp_q.size() > 0 && exp_q[0].cyc <= cur) begin
                e = exp_q.pop_front();
                if (e.cyc < cur) check_val({e.tag, "_missed"}, 32'd1, 32'd0);
                else             check_val(e.tag, get_sig(e.sel), e.val);
            end
        end
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic run_to(input int c);
        while (cur < c) step();
    endtask

    task automatic flush_pending();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val({e.tag, "_unreached"}, 32'd1, 32'd0);
        end
    endtask

    task automatic set_t(input int rc, input int rcd, input int rp, input int ras,
                         input int rfc, input int rtp, input int wtp, input int roc);
        t_rc_m1 = TW'(rc);  t_rcd_m1 = TW'(rcd); t_rp_m1 = TW'(rp);
        t_ras_m1 = TW'(ras); t_rfc_m1 = TW'(rfc); t_rtp_m1 = TW'(rtp);
        t_wtp_m1 = TW'(wtp); row_open_cnt = OCW'(roc);
    endtask

    task automatic do_reset();
        flush_pending();
        in_reset = 1'b1;
        rst_n = 1'b0;
        act_i = 0; rd_i = 0; wr_i = 0; pre_i = 0; ref_i = 0; row_i = '0;
        step();
        step();
        rst_n = 1'b1;
        in_reset = 1'b0;
        cur = 0;
    endtask

    initial begin
        cur = 0;
        set_t(0, 0, 0, 0, 0, 0, 0, 200);

        // ---------------- A: reset state and tRCD ----------------
        do_reset();
        set_t(0, 3, 0, 0, 0, 0, 0, 200);
        expect_at(0, S_ACT_OK, 1, "rst_act_ok");
        expect_at(0, S_REF_OK, 1, "rst_ref_ok");
        expect_at(0, S_RDWR_OK, 0, "rst_rdwr_ok");
        expect_at(0, S_PRE_OK, 0, "rst_pre_ok");
        expect_at(0, S_CLOSE, 0, "rst_close");
        expect_at(0, S_OPEN, 0, "rst_open");
        expect_at(0, S_ROW, 0, "rst_row");
        expect_at(0, S_ERR, 0, "rst_err");
        for (int c = 11; c <= 13; c++) expect_at(c, S_RDWR_OK, 0, "rcd_rdwr");
        expect_at(14, S_RDWR_OK, 1, "rcd_rdwr");
        expect_at(11, S_ROW, 32'hBEEF, "act_row");
        expect_at(11, S_OPEN, 1, "act_open");
        run_to(10);
        act_i = 1; row_i = 16'hBEEF; step(); act_i = 0;
        run_to(15);

        // ---------------- B: tRAS vs tRTP, tRP, tRFC ----------------
        do_reset();
        set_t(10, 0, 2, 7, 9, 2, 0, 200);
        expect_at(7, S_PRE_OK, 0, "rtp_pre");
        expect_at(8, S_PRE_OK, 0, "rtp_pre");
        expect_at(9, S_PRE_OK, 1, "rtp_pre");
        expect_at(21, S_ACT_OK, 0, "rp_act");
        expect_at(21, S_OPEN, 0, "pre_open");
        expect_at(22, S_ACT_OK, 0, "rp_act");
        expect_at(23, S_ACT_OK, 1, "rp_act");
        expect_at(23, S_REF_OK, 1, "rp_ref");
        expect_at(24, S_ACT_OK, 0, "rfc_act");
        expect_at(32, S_ACT_OK, 0, "rfc_act");
        expect_at(32, S_REF_OK, 0, "rfc_ref");
        expect_at(33, S_ACT_OK, 1, "rfc_act");
        expect_at(33, S_REF_OK, 1, "rfc_ref");
        expect_at(34, S_ERR, 0, "b_err");
        act_i = 1; row_i = 16'h0042; step(); act_i = 0;
        run_to(6);
        rd_i = 1; step(); rd_i = 0;
        run_to(20);
        pre_i = 1; step(); pre_i = 0;
        run_to(23);
        ref_i = 1; step(); ref_i = 0;
        run_to(35);

        // ---------------- C: open-row idle timer ----------------
        do_reset();
        set_t(0, 0, 0, 0, 0, 0, 0, 5);
        expect_at(5, S_CLOSE, 0, "idle_close");
        expect_at(6, S_CLOSE, 1, "idle_close");
        expect_at(11, S_CLOSE, 1, "idle_hold");
        expect_at(13, S_CLOSE, 0, "wr_close");
        expect_at(15, S_CLOSE, 0, "wr_close");
        expect_at(16, S_CLOSE, 1, "wr_close");
        expect_at(19, S_CLOSE, 0, "pre_close");
        expect_at(19, S_OPEN, 0, "pre_open");
        expect_at(22, S_CLOSE, 0, "cp_close");
        expect_at(23, S_CLOSE, 1, "cp_close");
        expect_at(25, S_CLOSE, 1, "cp_rd_close");
        act_i = 1; row_i = 16'h0007; step(); act_i = 0;
        run_to(12);
        row_open_cnt = 3; wr_i = 1; step(); wr_i = 0;
        run_to(18);
        pre_i = 1; step(); pre_i = 0;
        run_to(22);
        row_open_cnt = 0; act_i = 1; row_i = 16'h0008; step(); act_i = 0;
        run_to(24);
        rd_i = 1; step(); rd_i = 0;
        run_to(26);

        // ---------------- D: illegal commands ----------------
        do_reset();
        set_t(0, 5, 0, 0, 0, 0, 0, 200);
        expect_at(2, S_ERR, 0, "ill_err_pre");
        expect_at(3, S_ERR, 1, "ill_rd_idle_err");
        expect_at(3, S_OPEN, 0, "ill_rd_idle_open");
        expect_at(3, S_ACT_OK, 1, "ill_rd_idle_act_ok");
        expect_at(6, S_OPEN, 0, "ill_multi_open");
        expect_at(6, S_ROW, 0, "ill_multi_row");
        expect_at(9, S_OPEN, 1, "legal_act_open");
        expect_at(9, S_ERR, 1, "err_sticky");
        expect_at(13, S_ROW, 32'h00A5, "ill_act_row");
        expect_at(13, S_RDWR_OK, 0, "ill_rd_rcd");
        expect_at(14, S_RDWR_OK, 1, "ill_rd_rcd");
        expect_at(15, S_ERR, 1, "err_sticky");
        run_to(2);
        rd_i = 1; step(); rd_i = 0;
        run_to(5);
        act_i = 1; rd_i = 1; row_i = 16'h1111; step(); act_i = 0; rd_i = 0;
        run_to(8);
        act_i = 1; row_i = 16'h00A5; step(); act_i = 0;
        run_to(10);
        rd_i = 1; step(); rd_i = 0;
        wr_i = 1; step(); wr_i = 0;
        act_i = 1; row_i = 16'h5A5A; step(); act_i = 0;
        run_to(16);

        // ---------------- E: reset mid-ACTIVE / mid-REFRESH ----------------
        do_reset();
        set_t(50, 0, 0, 50, 30, 0, 0, 100);
        expect_at(4, S_ERR, 1, "e_err");
        expect_at(5, S_OPEN, 1, "mid_open");
        expect_at(5, S_ROW, 32'h1234, "mid_row");
        expect_at(5, S_ACT_OK, 0, "mid_act_ok");
        expect_at(6, S_OPEN, 0, "mrst_open");
        expect_at(6, S_ACT_OK, 1, "mrst_act_ok");
        expect_at(6, S_ROW, 0, "mrst_row");
        expect_at(6, S_ERR, 0, "mrst_err");
        expect_at(6, S_PRE_OK, 0, "mrst_pre_ok");
        expect_at(6, S_CLOSE, 0, "mrst_close");
        expect_at(9, S_ACT_OK, 0, "ref_act_ok");
        expect_at(12, S_ACT_OK, 1, "rrst_act_ok");
        expect_at(12, S_REF_OK, 1, "rrst_ref_ok");
        act_i = 1; row_i = 16'h1234; step(); act_i = 0;
        run_to(3);
        act_i = 1; pre_i = 1; step(); act_i = 0; pre_i = 0;
        run_to(5);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        run_to(8);
        ref_i = 1; step(); ref_i = 0;
        run_to(11);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        run_to(13);

        flush_pending();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sal_bank_timer.md
Name: sal_bank_timer

Overview:
Per-bank timing tracker and state machine that consumes the DRAM timing parameters distributed on TIMING_IF. It sits between the configuration block and the bank scheduler. It tracks the bank's IDLE, ACTIVE and REFRESH state, counts down each inter-command timing constraint, and tells the scheduler which command class is legal this cycle. It also raises an open-row timeout close request.

Parameters:
TW, 8, width of every timing counter and t_*_m1 input
ROW_W, 16, row address width
OCW, 8, width of row_open_cnt and the idle counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
t_rc_m1  in  TW  tRC-1 (ACT to ACT)
t_rcd_m1  in  TW  tRCD-1 (ACT to RD/WR)
t_rp_m1  in  TW  tRP-1 (PRE to ACT/REF)
t_ras_m1  in  TW  tRAS-1 (ACT to PRE)
t_rfc_m1  in  TW  tRFC-1 (REF to ACT/REF)
t_rtp_m1  in  TW  tRTP-1 (RD to PRE)
t_wtp_m1  in  TW  write-to-PRE - 1
row_open_cnt  in  OCW  idle cycles before close request
act_i  in  1  ACT issued this cycle
rd_i  in  1  RD issued this cycle
wr_i  in  1  WR issued this cycle
pre_i  in  1  PRE issued this cycle
ref_i  in  1  REF issued this cycle
row_i  in  ROW_W  row address, sampled with act_i
act_ok_o  out  1  ACT legal this cycle
rdwr_ok_o  out  1  RD/WR legal this cycle
pre_ok_o  out  1  PRE legal this cycle
ref_ok_o  out  1  REF legal this cycle
close_req_o  out  1  open-row timeout reached; PRE requested
is_open_o  out  1  bank in ACTIVE
cur_row_o  out  ROW_W  currently open row
err_o  out  1  sticky illegal-command flag

Behaviour:
- Timing inputs are quasi-static. They are sampled at each command issue and never re-read mid-count.
- Countdown counters: rc, rcd, ras, rp (also loaded with t_rfc_m1 on REF), rtp, wtp, idle.
  - A command at cycle N loads value_m1 at the clock edge ending cycle N.
  - The counter then decrements by 1 per cycle and saturates at 0.
  - "met" = counter==0. This is decoded combinationally from the count register, so with constraint X the dependent command is first legal at cycle N+X.
- States: IDLE, ACTIVE, REFRESH. Reset state is IDLE.
  - IDLE --act_i--> ACTIVE: load rc, rcd, ras; latch cur_row_o<=row_i; load idle.
  - IDLE --ref_i--> REFRESH: load rp with t_rfc_m1.
  - ACTIVE --rd_i--> ACTIVE: load rtp and idle.
  - ACTIVE --wr_i--> ACTIVE: load wtp and idle.
  - ACTIVE --pre_i--> IDLE: load rp.
  - REFRESH -> IDLE on the cycle rp reaches 0.
- Legality outputs:
  - act_ok = IDLE & rc_met & rp_met
  - ref_ok = IDLE & rp_met & rc_met
  - rdwr_ok = ACTIVE & rcd_met
  - pre_ok = ACTIVE & ras_met & rtp_met & wtp_met
- Illegal command handling. A command is illegal if either:
  - more than one strobe is asserted in a cycle, or
  - the strobe is asserted while its *_ok is 0.
  An illegal command is ignored (no state or counter change) and sets err_o. err_o clears only on reset.
- Idle timer:
  - Loaded with row_open_cnt on ACT, RD and WR.
  - close_req_o = ACTIVE & idle==0. It is held until PRE.
  - row_open_cnt=0 makes close_req_o assert on the cycle after each access (close-page policy).
- Reset values:
  - all counters 0
  - state IDLE, cur_row_o 0, err_o 0, close_req_o 0, is_open_o 0
  - act_ok_o=1, ref_ok_o=1, rdwr_ok_o=0, pre_ok_o=0
- Reset asserted mid-ACTIVE or mid-REFRESH returns to IDLE on the next edge and discards all counts.
- Counter width: no wrap. Decrement stops at 0.

Decomposition:
- Shared package: the bank state enum (IDLE, ACTIVE, REFRESH) and the TW/OCW defaults, so the scheduler and other banks share them.
- One natural sub-module: sal_dn_cnt. It is a loadable saturating down-counter with a met output, instantiated once per constraint.

Test Plan:
- Reset, then t_rcd_m1=3: ACT at cycle 10 -> rdwr_ok_o=0 for cycles 11-13, =1 at cycle 14. cur_row_o=row_i.
- t_ras_m1=7, t_rtp_m1=2: ACT at cycle 0, RD at cycle 6 -> pre_ok_o first 1 at cycle 9, because tRTP dominates over tRAS (8).
- t_rp_m1=2: PRE at cycle 20 -> act_ok_o first 1 at cycle 23. REF at cycle 23 with t_rfc_m1=9 -> REFRESH, act_ok_o=0 until cycle 33.
- row_open_cnt=5: ACT at cycle 0, no further access -> close_req_o rises at cycle 6 and stays until PRE. With row_open_cnt=0: RD at cycle 4 -> close_req_o at cycle 5.
- Illegal commands: rd_i in IDLE, and act_i+rd_i together -> err_o=1, state and counters unchanged. err_o stays 1 until rst_n=0.
- rst_n=0 mid-ACTIVE with counters nonzero -> next cycle IDLE, act_ok_o=1, is_open_o=0, cur_row_o=0.
